tick_gen: RTL and testbench
===========================

TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent tick channels.
REQ-002 Parameter CW, default 25: divisor/counter width in bits.
REQ-003 Parameter DEF_DIV, default 27000000: divisor every channel holds after reset (1 s on 27 MHz clk).
REQ-004 Parameter DBG_STEP, default 10: counter increment per cycle when debug=1.
REQ-005 clk  input  1  system clock; all state on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; clears all state immediately.
REQ-007 debug  input  1  1 = accelerated mode, counters advance by DBG_STEP per cycle.
REQ-008 en  input  NUM_CH  per-channel run enable.
REQ-009 load_valid  input  1  divisor load request.
REQ-010 load_ch  input  clog2(NUM_CH)  target channel of the load.
REQ-011 load_div  input  CW  requested divisor.
REQ-012 load_ready  output  1  load accepted when load_valid & load_ready.
REQ-013 tick  output  NUM_CH  registered one-cycle pulse at the end of each period.
REQ-014 half  output  NUM_CH  registered one-cycle pulse at the mid-period point and at the end of each period.

Function
REQ-015 Each channel SHALL hold cnt (CW bits), div_act, div_shadow, pending flag and state IDLE/RUN.
REQ-016 STEP SHALL be DBG_STEP when debug=1, else 1, sampled every cycle; a change takes effect on the next edge without clearing cnt.
REQ-017 cnt+STEP SHALL be computed in CW+1 bits; no wrap-around.
REQ-018 IDLE -> RUN when en[i]=1; RUN -> IDLE when en[i]=0; in IDLE, cnt=0 and tick[i]=half[i]=0.
REQ-019 In RUN, if cnt+STEP >= div_act: cnt<=0, tick[i]<=1, half[i]<=1; otherwise cnt<=cnt+STEP, tick[i]<=0.
REQ-020 In RUN, half[i]<=1 also when cnt < (div_act>>1) and cnt+STEP >= (div_act>>1); otherwise half[i]<=0.
REQ-021 With STEP=1 the tick period SHALL be exactly div_act cycles; with STEP=DBG_STEP it SHALL be ceil(div_act/DBG_STEP) cycles.
REQ-022 First tick after the IDLE->RUN transition SHALL occur div_act cycles after the first cycle en[i] is sampled high (STEP=1).
REQ-023 load_ready SHALL equal !pending[load_ch] combinationally; load_ch >= NUM_CH SHALL make load_ready=0 and the load is ignored.
REQ-024 An accepted load with load_div < 2 SHALL be stored as 2.
REQ-025 Accepted load to an IDLE channel SHALL write div_act directly; pending stays 0.
REQ-026 Accepted load to a RUN channel SHALL write div_shadow and set pending; at that channel's next terminal count div_act<=div_shadow and pending<=0.
REQ-027 A load accepted in the same cycle as that channel's terminal count SHALL set pending and apply at the following terminal count.
REQ-028 A load accepted in the same cycle the channel leaves RUN SHALL be treated as a RUN-channel load (goes to shadow); on the next IDLE cycle pending SHALL be applied to div_act and cleared.
REQ-029 If cnt >= div_act after a debug change, the next RUN cycle SHALL be a terminal count.
REQ-030 Channels SHALL be fully independent; simultaneous terminal counts on several channels all pulse in the same cycle.

Reset
REQ-031 On reset=0: cnt=0, state=IDLE, div_act=DEF_DIV, div_shadow=DEF_DIV, pending=0, tick=0, half=0, asynchronously.
REQ-032 load_ready SHALL read 1 during and after reset for any valid load_ch.
REQ-033 Reset asserted mid-period SHALL discard the period; after release the channel restarts per REQ-022.

Verification
REQ-034 Load ch0 div=4 while IDLE, en[0]=1, debug=0 -> half[0] every 2 cycles, tick[0] every 4 cycles, first tick 4 cycles after en.
REQ-035 Ch1 div=100, debug=1 -> tick[1] every 10 cycles; ch2 div=105, debug=1 -> every 11 cycles.
REQ-036 Ch0 running div=8, load div=3 mid-period -> load_ready[ch0]=0 until terminal; current period 8 cycles, next periods 3 cycles; second load during pending is refused.
REQ-037 Load div=0 and div=1 -> both behave as div=2: tick every 2 cycles, half every cycle.
REQ-038 Ch3 div=50, debug switched 0->1 at cnt=45 -> terminal count on next cycle, then 5-cycle periods.
REQ-039 Reset pulsed low mid-period with all channels running -> all outputs 0 immediately, divisors back to 27000000, load_ready=1.

Source files
------------

// File: rtl/tick_gen_if.sv
// Divisor-load handshake between a host and the tick generator.
// The host offers a divisor for one channel; the generator accepts it when ready.
interface tick_gen_if #(
    parameter int NUM_CH = 4,
    parameter int CW     = 25
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic           load_valid;
    logic [CHW-1:0] load_ch;
    logic [CW-1:0]  load_div;
    logic           load_ready;

    modport master (output load_valid, load_ch, load_div, input  load_ready);
    modport slave  (input  load_valid, load_ch, load_div, output load_ready);
endinterface

// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator: each channel divides clk by its own
// divisor, pulsing tick at period end and half at mid-period and period end.
module tick_gen #(
    parameter int NUM_CH   = 4,
    parameter int CW       = 25,
    parameter int DEF_DIV  = 27000000,
    parameter int DBG_STEP = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              debug,
    input  logic [NUM_CH-1:0] en,
    tick_gen_if.slave         load,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] half
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    logic [CW:0]       step;
    logic [CW-1:0]     load_val;
    logic              ch_ok;
    logic              load_acc;
    logic [NUM_CH-1:0] pend_vec;

    assign step            = debug ? (CW+1)'(DBG_STEP) : (CW+1)'(1);
    assign load_val        = (load.load_div < CW'(2)) ? CW'(2) : load.load_div;
    assign ch_ok           = ({1'b0, load.load_ch} < (CHW+1)'(NUM_CH));
    assign load.load_ready = ch_ok && !pend_vec[load.load_ch];
    assign load_acc        = load.load_valid && load.load_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [CW-1:0] div_act_q, div_act_d;
        logic [CW-1:0] div_sh_q, div_sh_d;
        logic          pend_q, pend_d;
        logic          tick_q, tick_d;
        logic          half_q, half_d;
        logic [CW:0]   sum;
        logic [CW-1:0] mid;
        logic          term, mid_hit, load_hit;

        // One extra bit on the sum so a large step never wraps past the divisor.
        assign sum      = {1'b0, cnt_q} + step;
        assign mid      = div_act_q >> 1;
        assign term     = sum >= {1'b0, div_act_q};
        assign mid_hit  = (cnt_q < mid) && (sum >= {1'b0, mid});
        assign load_hit = load_acc && (load.load_ch == CHW'(i));

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            div_act_d = div_act_q;
            div_sh_d  = div_sh_q;
            pend_d    = pend_q;
            tick_d    = 1'b0;
            half_d    = 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (pend_q) begin
                        div_act_d = div_sh_q;
                        pend_d    = 1'b0;
                    end
                    if (load_hit) div_act_d = load_val;
                    if (en[i]) state_d = S_RUN;
                end
                default: begin
                    if (!en[i]) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (term) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        half_d = 1'b1;
                        if (pend_q) begin
                            div_act_d = div_sh_q;
                            pend_d    = 1'b0;
                        end
                    end else begin
                        cnt_d  = sum[CW-1:0];
                        half_d = mid_hit;
                    end
                    // A load landing on a terminal count waits for the next one.
                    if (load_hit) begin
                        div_sh_d = load_val;
                        pend_d   = 1'b1;
                    end
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q   <= S_IDLE;
                cnt_q     <= '0;
                div_act_q <= CW'(DEF_DIV);
                div_sh_q  <= CW'(DEF_DIV);
                pend_q    <= 1'b0;
                tick_q    <= 1'b0;
                half_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                div_act_q <= div_act_d;
                div_sh_q  <= div_sh_d;
                pend_q    <= pend_d;
                tick_q    <= tick_d;
                half_q    <= half_d;
            end
        end

        assign pend_vec[i] = pend_q;
        assign tick[i]     = tick_q;
        assign half[i]     = half_q;
    end
endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen: table of per-channel divisor scenarios plus
// hand-written sequences for reloads, debug switching and asynchronous reset.
module tb_tick_gen;
    localparam int NUM_CH = 4;
    localparam int CW     = 25;
    localparam int LIMIT  = 300;

    logic              clk;
    logic              reset;
    logic              debug;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] half;

    tick_gen_if #(.NUM_CH(NUM_CH), .CW(CW)) bus ();

    tick_gen #(.NUM_CH(NUM_CH), .CW(CW), .DEF_DIV(27000000), .DBG_STEP(10)) dut (
        .clk   (clk),
        .reset (reset),
        .debug (debug),
        .en    (en),
        .load  (bus),
        .tick  (tick),
        .half  (half)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int div;
        bit dbg;
        int first;
        int period;
        int hoff;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        en    = '0;
        debug = 1'b0;
        bus.load_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_load(input int ch, input int div, input string name);
        bus.load_valid = 1'b1;
        bus.load_ch    = ch[1:0];
        bus.load_div   = div[CW-1:0];
        chk(name, bus.load_ready, 1);
        @(negedge clk);
        bus.load_valid = 1'b0;
    endtask

    // Counts falling edges until tick[ch]; n = -1 if the budget runs out.
    task automatic run_to_tick(input int ch, output int n, output int hfirst, output int hcnt);
        n = -1;
        hfirst = -1;
        hcnt = 0;
        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge clk);
            if (half[ch] === 1'b1) begin
                hcnt++;
                if (hfirst < 0) hfirst = k;
            end
            if (tick[ch] === 1'b1) begin
                n = k;
                return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, hf, hc, k, bad, cnt;

        vecs[0] = '{ch: 0, div: 4,   dbg: 1'b0, first: 4,  period: 4,  hoff: 2};
        vecs[1] = '{ch: 1, div: 100, dbg: 1'b1, first: 10, period: 10, hoff: 5};
        vecs[2] = '{ch: 2, div: 105, dbg: 1'b1, first: 11, period: 11, hoff: 6};
        vecs[3] = '{ch: 0, div: 0,   dbg: 1'b0, first: 2,  period: 2,  hoff: 1};
        vecs[4] = '{ch: 3, div: 1,   dbg: 1'b0, first: 2,  period: 2,  hoff: 1};
        vecs[5] = '{ch: 2, div: 7,   dbg: 1'b0, first: 7,  period: 7,  hoff: 3};
        vecs[6] = '{ch: 1, div: 27,  dbg: 1'b1, first: 3,  period: 3,  hoff: 2};

        reset = 1'b0;
        en = '0;
        debug = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_ch = '0;
        bus.load_div = '0;
        @(negedge clk);
        chk("rst_tick", tick, 0);
        chk("rst_half", half, 0);
        chk("rst_ready", bus.load_ready, 1);

        foreach (vecs[v]) begin
            do_reset();
            debug = vecs[v].dbg;
            do_load(vecs[v].ch, vecs[v].div, $sformatf("v%0d_ready", v));
            en[vecs[v].ch] = 1'b1;
            @(negedge clk);
            run_to_tick(vecs[v].ch, n, hf, hc);
            chk($sformatf("v%0d_first", v), n, vecs[v].first);
            run_to_tick(vecs[v].ch, n, hf, hc);
            chk($sformatf("v%0d_period", v), n, vecs[v].period);
            chk($sformatf("v%0d_half_off", v), hf, vecs[v].hoff);
            chk($sformatf("v%0d_half_cnt", v), hc, 2);
        end

        // Reload while running: refused while pending, applied at terminal count.
        do_reset();
        do_load(0, 8, "a_ready_idle");
        en[0] = 1'b1;
        @(negedge clk);
        run_to_tick(0, n, hf, hc);
        chk("a_first", n, 8);
        @(negedge clk);
        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_ch = 2'd0;
        bus.load_div = CW'(3);
        chk("a_ready_run", bus.load_ready, 1);
        @(negedge clk);
        bus.load_div = CW'(5);
        k = 3;
        bad = 0;
        while (tick[0] !== 1'b1 && k < 40) begin
            if (bus.load_ready !== 1'b0) bad++;
            @(negedge clk);
            k++;
        end
        bus.load_valid = 1'b0;
        chk("a_cur_period", k, 8);
        chk("a_refused", bad, 0);
        chk("a_ready_after", bus.load_ready, 1);
        run_to_tick(0, n, hf, hc);
        chk("a_new_period1", n, 3);
        run_to_tick(0, n, hf, hc);
        chk("a_new_period2", n, 3);

        // Debug switched on near the end of a period.
        do_reset();
        do_load(3, 50, "b_ready");
        en[3] = 1'b1;
        @(negedge clk);
        run_to_tick(3, n, hf, hc);
        chk("b_first", n, 50);
        repeat (45) @(negedge clk);
        debug = 1'b1;
        run_to_tick(3, n, hf, hc);
        chk("b_term_next", n, 1);
        run_to_tick(3, n, hf, hc);
        chk("b_period1", n, 5);
        run_to_tick(3, n, hf, hc);
        chk("b_period2", n, 5);

        // Load accepted on the terminal-count cycle.
        do_reset();
        do_load(1, 4, "c_ready_idle");
        en[1] = 1'b1;
        @(negedge clk);
        run_to_tick(1, n, hf, hc);
        repeat (3) @(negedge clk);
        do_load(1, 6, "c_ready_term");
        chk("c_term_tick", tick[1], 1);
        chk("c_pending", bus.load_ready, 0);
        run_to_tick(1, n, hf, hc);
        chk("c_old_div", n, 4);
        run_to_tick(1, n, hf, hc);
        chk("c_new_div", n, 6);

        // Load accepted on the cycle the channel leaves RUN.
        do_reset();
        do_load(2, 4, "d_ready_idle");
        en[2] = 1'b1;
        @(negedge clk);
        run_to_tick(2, n, hf, hc);
        @(negedge clk);
        en[2] = 1'b0;
        do_load(2, 9, "d_ready_leave");
        bus.load_ch = 2'd2;
        chk("d_pending_idle", bus.load_ready, 0);
        chk("d_idle_tick", tick[2], 0);
        @(negedge clk);
        chk("d_applied", bus.load_ready, 1);
        en[2] = 1'b1;
        @(negedge clk);
        run_to_tick(2, n, hf, hc);
        chk("d_first", n, 9);

        // All channels in lock-step, then asynchronous reset on a tick cycle.
        do_reset();
        for (int c = 0; c < NUM_CH; c++) do_load(c, 5, $sformatf("e_ready%0d", c));
        en = '1;
        @(negedge clk);
        run_to_tick(0, n, hf, hc);
        chk("e_first", n, 5);
        chk("e_all_tick", tick, 4'hF);
        chk("e_all_half", half, 4'hF);
        #2 reset = 1'b0;
        #1;
        chk("f_tick_async", tick, 0);
        chk("f_half_async", half, 0);
        for (int c = 0; c < NUM_CH; c++) begin
            bus.load_ch = c[1:0];
            #1 chk($sformatf("f_ready%0d", c), bus.load_ready, 1);
        end
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if ((tick | half) != '0) cnt++;
        end
        chk("f_div_default", cnt, 0);
        en = '0;
        @(negedge clk);
        do_load(0, 6, "f_ready_reload");
        en[0] = 1'b1;
        @(negedge clk);
        run_to_tick(0, n, hf, hc);
        chk("f_restart", n, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
